// File: rtl/piano_voice_n.sv
// piano_voice_n: N debounced keys drive one PWM-gated square-wave voice with last-pressed-wins and a sustain tail
module piano_voice_n #(
  parameter int NKEYS = 4,
  parameter int WIDTH = 15,
  parameter logic [NKEYS*WIDTH-1:0] HALF_PERIODS = {4{15'd13378}},
  parameter int DEBOUNCE = 35000,
  parameter int DBW = 16,
  parameter int SUSTAIN = 700000,
  parameter int SW = 20,
  parameter int VOLW = 8,
  localparam int NW = NKEYS > 1 ? $clog2(NKEYS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NKEYS-1:0] keys,
  input  logic [1:0]      octave,
  input  logic [VOLW-1:0] volume,
  output logic            buzzer,
  output logic            active,
  output logic [NW-1:0]   note
);
  typedef enum logic [1:0] {IDLE, PLAY, SUST} state_t;
  state_t state, state_n;
  logic [NKEYS-1:0] s1, s2, deb, deb_q, press, rel;
  logic [DBW-1:0] dcnt [NKEYS];
  logic [SW-1:0] scnt;
  logic [WIDTH-1:0] tcnt, hp, sh, load;
  logic [VOLW-1:0] p;
  logic [NW-1:0] note_n;
  logic wave, restart;
  function automatic logic [NW-1:0] lowest(input logic [NKEYS-1:0] v);
    lowest = '0;
    for (int i = NKEYS - 1; i >= 0; i--) if (v[i]) lowest = NW'(i);
  endfunction
  // a key's debounced level follows the synced level only after DEBOUNCE disagreeing cycles in a row
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      deb_q <= '0;
      for (int i = 0; i < NKEYS; i++) dcnt[i] <= '0;
    end else begin
      s1 <= keys;
      s2 <= s1;
      deb_q <= deb;
      for (int i = 0; i < NKEYS; i++) begin
        if (s2[i] == deb[i]) dcnt[i] <= '0;
        else if (dcnt[i] == DBW'(DEBOUNCE - 1)) begin
          dcnt[i] <= '0;
          deb[i] <= s2[i];
        end else dcnt[i] <= dcnt[i] + 1'b1;
      end
    end
  end
  assign press = deb & ~deb_q;
  assign rel = ~deb & deb_q;
  always_comb begin
    state_n = state;
    note_n = note;
    case (state)
      IDLE: if (|press) begin
        state_n = PLAY;
        note_n = lowest(press);
      end
      PLAY: if (|press) note_n = lowest(press);
        else if (deb == '0) state_n = SUST;
        else if (rel[note]) note_n = lowest(deb);
      SUST: if (|press) begin
        state_n = PLAY;
        note_n = lowest(press);
      end else if (scnt == SW'(1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign restart = (state_n == PLAY) && ((|press) || (note_n != note));
  assign hp = HALF_PERIODS[int'(note_n)*WIDTH +: WIDTH];
  assign sh = hp >> octave;
  assign load = (sh == '0) ? WIDTH'(1) : sh;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      note <= '0;
      active <= 1'b0;
      buzzer <= 1'b0;
      wave <= 1'b0;
      tcnt <= '0;
      scnt <= '0;
      p <= '0;
    end else begin
      state <= state_n;
      note <= note_n;
      active <= (state_n != IDLE);
      p <= p + 1'b1;
      buzzer <= (state != IDLE) & wave & (p < volume);
      scnt <= (state == PLAY && state_n == SUST) ? SW'(SUSTAIN) :
              (state == SUST && scnt != '0) ? scnt - 1'b1 : scnt;
      if (restart) begin
        wave <= 1'b0;
        tcnt <= load;
      end else if (state == IDLE) wave <= 1'b0;
      else if (tcnt == WIDTH'(1)) begin
        wave <= ~wave;
        tcnt <= load;
      end else tcnt <= tcnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_piano_voice_n.sv
// tb_piano_voice_n: directed scoreboard bench for piano_voice_n with small debounce/sustain parameters
module tb_piano_voice_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] keys = '0;
  logic [1:0] octave = 2'd0;
  logic [1:0] volume = 2'd3;
  logic buzzer, active, b1, a1;
  logic [1:0] note, n1;
  int n_chk = 0;
  int n_fail = 0;
  string tq[$];
  int lq[$];
  int hq[$];

  always #5 clk = ~clk;

  piano_voice_n #(.NKEYS(4), .WIDTH(8), .HALF_PERIODS({8'd40, 8'd30, 8'd20, 8'd10}),
    .DEBOUNCE(4), .DBW(3), .SUSTAIN(20), .SW(5), .VOLW(2)) dut (
    .clk(clk), .rst_n(rst_n), .keys(keys), .octave(octave), .volume(volume),
    .buzzer(buzzer), .active(active), .note(note));

  // second voice whose key0 half-period shifts down to zero at octave 3
  piano_voice_n #(.NKEYS(4), .WIDTH(8), .HALF_PERIODS({8'd40, 8'd30, 8'd20, 8'd1}),
    .DEBOUNCE(4), .DBW(3), .SUSTAIN(20), .SW(5), .VOLW(2)) u1 (
    .clk(clk), .rst_n(rst_n), .keys(keys), .octave(octave), .volume(volume),
    .buzzer(b1), .active(a1), .note(n1));

  task automatic exp_push(input string t, input int lo, input int hi);
    tq.push_back(t);
    lq.push_back(lo);
    hq.push_back(hi);
  endtask

  task automatic observe(input int got);
    string t;
    int lo, hi;
    bit ok;
    n_chk++;
    if (tq.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0d", got);
    end else begin
      t = tq.pop_front();
      lo = lq.pop_front();
      hi = hq.pop_front();
      ok = (got >= lo) && (got <= hi);
      assert (ok === 1'b1) else begin
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d..%0d", t, got, lo, hi);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic pick(input int sel);
    return sel == 0 ? buzzer : sel == 1 ? b1 : active;
  endfunction

  task automatic first_high(input int sel, input int max, output int f);
    f = max + 1;
    for (int i = 1; i <= max && f > max; i++) begin
      @(negedge clk);
      if (pick(sel) === 1'b1) f = i;
    end
  endtask

  task automatic count_sig(input int sel, input int n, output int c, output int pairs);
    logic prev, cur;
    prev = 1'b0;
    c = 0;
    pairs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cur = pick(sel);
      if (cur === 1'b1) c++;
      if (cur === 1'b1 && prev === 1'b1) pairs++;
      prev = cur;
    end
  endtask

  initial begin
    int f, c, pr;
    tick(2);
    exp_push("rst_buzzer", 0, 0);
    exp_push("rst_active", 0, 0);
    exp_push("rst_note", 0, 0);
    observe(int'(buzzer));
    observe(int'(active));
    observe(int'(note));
    rst_n = 1'b1;
    // debounce: short glitch rejected, held key accepted after 2+4+1 cycles
    keys = 4'b0010;
    tick(3);
    keys = 4'b0000;
    exp_push("glitch_active_count", 0, 0);
    count_sig(2, 12, c, pr);
    observe(c);
    keys = 4'b0010;
    exp_push("deb_c6_active", 0, 0);
    tick(6);
    observe(int'(active));
    exp_push("deb_c7_active", 1, 1);
    exp_push("deb_c7_note", 1, 1);
    tick(1);
    observe(int'(active));
    observe(int'(note));
    exp_push("note1_first_high", 21, 22);
    first_high(0, 30, f);
    observe(f);
    exp_push("note1_pwm_80", 30, 30);
    count_sig(0, 80, c, pr);
    observe(c);
    // priority
    keys = 4'b0011;
    exp_push("key0_c6_note", 1, 1);
    tick(6);
    observe(int'(note));
    exp_push("key0_note", 0, 0);
    tick(1);
    observe(int'(note));
    keys = 4'b0001;
    exp_push("rel_other_note", 0, 0);
    tick(8);
    observe(int'(note));
    keys = 4'b0101;
    exp_push("key2_note", 2, 2);
    tick(7);
    observe(int'(note));
    exp_push("note2_first_high", 31, 32);
    first_high(0, 40, f);
    observe(f);
    keys = 4'b0001;
    exp_push("rel_key2_note", 0, 0);
    tick(7);
    observe(int'(note));
    keys = 4'b1011;
    exp_push("k1k3_note", 1, 1);
    tick(7);
    observe(int'(note));
    // simultaneous release and press
    keys = 4'b0001;
    exp_push("rel_cur_note", 0, 0);
    tick(7);
    observe(int'(note));
    keys = 4'b0100;
    exp_push("swap_note", 2, 2);
    tick(7);
    observe(int'(note));
    exp_push("swap_active_40", 40, 40);
    count_sig(2, 40, c, pr);
    observe(c);
    // sustain tail
    keys = 4'b0000;
    exp_push("sus_note", 2, 2);
    tick(7);
    observe(int'(note));
    exp_push("sus_c26_active", 1, 1);
    tick(19);
    observe(int'(active));
    exp_push("sus_c27_active", 0, 0);
    tick(1);
    observe(int'(active));
    exp_push("sus_idle_buzzer", 0, 0);
    count_sig(0, 13, c, pr);
    observe(c);
    keys = 4'b1000;
    exp_push("k3_note", 3, 3);
    tick(7);
    observe(int'(note));
    keys = 4'b0000;
    tick(10);
    keys = 4'b1000;
    exp_push("sus_c16_active", 1, 1);
    tick(6);
    observe(int'(active));
    exp_push("resume_note", 3, 3);
    exp_push("resume_active", 1, 1);
    tick(1);
    observe(int'(note));
    observe(int'(active));
    exp_push("resume_first_high", 41, 42);
    first_high(0, 50, f);
    observe(f);
    // octave and volume
    keys = 4'b0000;
    tick(40);
    exp_push("idle_active", 0, 0);
    observe(int'(active));
    octave = 2'd2;
    keys = 4'b1000;
    exp_push("oct2_note", 3, 3);
    tick(7);
    observe(int'(note));
    exp_push("oct2_first_high", 11, 12);
    first_high(0, 20, f);
    observe(f);
    exp_push("oct2_pwm_40", 14, 16);
    count_sig(0, 40, c, pr);
    observe(c);
    keys = 4'b0000;
    octave = 2'd3;
    tick(40);
    keys = 4'b0001;
    exp_push("min_load_active", 1, 1);
    tick(7);
    observe(int'(a1));
    exp_push("min_load_first_high", 2, 4);
    first_high(1, 6, f);
    observe(f);
    exp_push("min_load_pairs", 0, 0);
    exp_push("min_load_count", 4, 8);
    count_sig(1, 16, c, pr);
    observe(pr);
    observe(c);
    volume = 2'd0;
    tick(2);
    exp_push("vol0_buzzer", 0, 0);
    exp_push("vol0_u1_buzzer", 0, 0);
    exp_push("vol0_active", 1, 1);
    count_sig(0, 20, c, pr);
    observe(c);
    count_sig(1, 20, c, pr);
    observe(c);
    observe(int'(active));
    // reset mid-tone
    volume = 2'd3;
    octave = 2'd0;
    keys = 4'b0100;
    exp_push("pre_rst_note", 2, 2);
    tick(7);
    observe(int'(note));
    exp_push("pre_rst_pwm_60", 22, 23);
    count_sig(0, 60, c, pr);
    observe(c);
    tick(30);
    rst_n = 1'b0;
    exp_push("rst_mid_buzzer", 0, 0);
    exp_push("rst_mid_active", 0, 0);
    exp_push("rst_mid_note", 0, 0);
    tick(1);
    observe(int'(buzzer));
    observe(int'(active));
    observe(int'(note));
    rst_n = 1'b1;
    exp_push("rst_c6_active", 0, 0);
    tick(6);
    observe(int'(active));
    exp_push("rst_c7_active", 1, 1);
    exp_push("rst_c7_note", 2, 2);
    tick(1);
    observe(int'(active));
    observe(int'(note));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
